// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, RGB332 field widths and delay-line payload for vga_timing_gen.
// VGA_TEST_PATTERN_EN adds the colour-bar index to the payload.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 1024;
    localparam int H_FP_DEF     = 24;
    localparam int H_SYNC_DEF   = 136;
    localparam int H_BP_DEF     = 160;
    localparam int V_ACTIVE_DEF = 768;
    localparam int V_FP_DEF     = 3;
    localparam int V_SYNC_DEF   = 6;
    localparam int V_BP_DEF     = 29;
    localparam int PIPE_LAT_DEF = 2;

    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
    localparam int VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

    localparam int H_CNT_W = 11;
    localparam int V_CNT_W = 10;

    localparam int RED_W   = 3;
    localparam int GREEN_W = 3;
    localparam int BLUE_W  = 2;
    localparam int PIXEL_W = RED_W + GREEN_W + BLUE_W;

    typedef logic [PIXEL_W-1:0] rgb332_t;

    typedef enum logic {
        ST_PRESTART,
        ST_RUN
    } gen_state_t;

`ifdef VGA_TEST_PATTERN_EN
    typedef struct packed {
        logic       active;
        logic       hs_n;
        logic       vs_n;
        logic [2:0] bar;
    } pipe_payload_t;

    localparam pipe_payload_t PAYLOAD_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1, bar: 3'd0};
`else
    typedef struct packed {
        logic active;
        logic hs_n;
        logic vs_n;
    } pipe_payload_t;

    localparam pipe_payload_t PAYLOAD_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1};
`endif

    // Each bit of the bar index fans out across a whole colour field.
    function automatic rgb332_t bar_colour(input logic [2:0] idx);
        return {{RED_W{idx[2]}}, {GREEN_W{idx[1]}}, {BLUE_W{idx[0]}}};
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel request bus between the timing generator (master) and the pixel source (slave).
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic [H_CNT_W-1:0] req_x;
    logic [V_CNT_W-1:0] req_y;
    logic               req_active;
    logic               frame_start;
    logic [PIXEL_W-1:0] pixel_in;

    modport master (
        output req_x, req_y, req_active, frame_start,
        input  pixel_in
    );

    modport slave (
        input  req_x, req_y, req_active, frame_start,
        output pixel_in
    );
endinterface

// File: rtl/vga_delay_line.sv
// Generic WIDTH x DEPTH shift register with asynchronous active-low reset to RESET_VAL.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: every stage is reset, not just the head: stale sync/active bits
            // left in the line would otherwise leak a partial pulse after release.
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            // NOTE: non-blocking assignments let each stage take its neighbour's old value.
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// 1024x768@60 VGA timing: pixel requests, latency-matched sync/blank, registered pins.
// VGA_TEST_PATTERN_EN enables the colour-bar substitution selected by pattern_sel.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF  // legal range 1..8
) (
    input  logic               clock,
    input  logic               reset,
    vga_timing_gen_if.master   req,
    input  logic               pattern_sel,
    output logic [RED_W-1:0]   vgaRed,
    output logic [GREEN_W-1:0] vgaGreen,
    output logic [BLUE_W-1:0]  vgaBlue,
    output logic               Hsync,
    output logic               Vsync
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    gen_state_t         state_q, state_d;
    logic [H_CNT_W-1:0] h_q, h_d;
    logic [V_CNT_W-1:0] v_q, v_d;
    logic               active_q, active_d;
    logic               frame_start_q, frame_start_d;
    logic               hs_n_q, hs_n_d;
    logic               vs_n_q, vs_n_d;

    // The first edge after reset only loads the decodes for (0,0); counting starts after it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        unique case (state_q)
            ST_PRESTART: state_d = ST_RUN;
            ST_RUN: begin
                if (int'(h_q) == H_TOTAL - 1) begin
                    h_d = '0;
                    v_d = (int'(v_q) == V_TOTAL - 1) ? '0 : v_q + V_CNT_W'(1);
                end else begin
                    h_d = h_q + H_CNT_W'(1);
                end
            end
            default: state_d = ST_PRESTART;
        endcase

        active_d      = (int'(h_d) < H_ACTIVE) && (int'(v_d) < V_ACTIVE);
        frame_start_d = (h_d == '0) && (v_d == '0);
        hs_n_d        = !((int'(h_d) >= HS_START) && (int'(h_d) <= HS_END));
        vs_n_d        = !((int'(v_d) >= VS_START) && (int'(v_d) <= VS_END));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_PRESTART;
            h_q           <= '0;
            v_q           <= '0;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
            hs_n_q        <= 1'b1;
            vs_n_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
            hs_n_q        <= hs_n_d;
            vs_n_q        <= vs_n_d;
        end
    end

    assign req.req_x       = h_q;
    assign req.req_y       = v_q;
    assign req.req_active  = active_q;
    assign req.frame_start = frame_start_q;

    pipe_payload_t req_payload;
    pipe_payload_t dly_payload;

    always_comb begin
        req_payload        = PAYLOAD_IDLE;
        req_payload.active = active_q;
        req_payload.hs_n   = hs_n_q;
        req_payload.vs_n   = vs_n_q;
`ifdef VGA_TEST_PATTERN_EN
        req_payload.bar    = h_q[9:7];
`endif
    end

    vga_delay_line #(
        .WIDTH    ($bits(pipe_payload_t)),
        .DEPTH    (PIPE_LAT),
        .RESET_VAL(PAYLOAD_IDLE)
    ) u_delay (
        .clock(clock),
        .reset(reset),
        .d_i  (req_payload),
        .q_o  (dly_payload)
    );

    rgb332_t rgb_d, rgb_q;
    logic    hsync_q, vsync_q;

    // pixel_in is sampled every cycle; anything outside the active window is discarded.
    always_comb begin
        rgb_d = '0;
        if (dly_payload.active) begin
`ifdef VGA_TEST_PATTERN_EN
            rgb_d = pattern_sel ? bar_colour(dly_payload.bar) : req.pixel_in;
`else
            rgb_d = req.pixel_in;
`endif
        end
    end

`ifndef VGA_TEST_PATTERN_EN
    logic unused_pattern_sel;
    assign unused_pattern_sel = pattern_sel;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rgb_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= dly_payload.hs_n;
            vsync_q <= dly_payload.vs_n;
        end
    end

    assign {vgaRed, vgaGreen, vgaBlue} = rgb_q;
    assign Hsync = hsync_q;
    assign Vsync = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: full horizontal timing, shortened vertical frame.
module tb_vga_timing_gen;

    localparam int LAT     = 2;
    localparam int OUT_LAT = LAT + 1;
    localparam int HA = 1024, HF = 24, HS = 136, HB = 160;
    localparam int VA = 16, VF = 3, VS = 6, VB = 4;
    localparam int HT    = HA + HF + HS + HB;
    localparam int VT    = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    typedef struct {
        int         x;
        int         y;
        bit         act;
        bit         fs;
        bit         hs;
        bit         vs;
        logic [7:0] rgb;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       pattern_sel = 1'b0;
    logic [2:0] vgaRed, vgaGreen;
    logic [1:0] vgaBlue;
    logic       Hsync, Vsync;
    logic [7:0] rgb_pins;

    vga_timing_gen_if bus ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIPE_LAT(LAT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (bus),
        .pattern_sel(pattern_sel),
        .vgaRed     (vgaRed),
        .vgaGreen   (vgaGreen),
        .vgaBlue    (vgaBlue),
        .Hsync      (Hsync),
        .Vsync      (Vsync)
    );

    assign rgb_pins = {vgaRed, vgaGreen, vgaBlue};

    always #5 clock = ~clock;

    int         n;          // clock edges since reset release; 0 while in reset
    int         n_checks;
    int         n_fails;
    logic [7:0] salt;
    logic [7:0] hist1, hist2;

    // Expected state after edge k, derived from raster position arithmetic.
    function automatic exp_t model_at(input int k);
        exp_t       e;
        int         p, qx, qy, idx;
        logic [7:0] xb;
        e.x = 0; e.y = 0; e.act = 1'b0; e.fs = 1'b0;
        e.hs = 1'b1; e.vs = 1'b1; e.rgb = 8'h00;
        if (k >= 1) begin
            p     = (k - 1) % FRAME;
            e.x   = p % HT;
            e.y   = p / HT;
            e.act = (e.x < HA) && (e.y < VA);
            e.fs  = (p == 0);
        end
        if (k - OUT_LAT >= 1) begin
            p    = (k - OUT_LAT - 1) % FRAME;
            qx   = p % HT;
            qy   = p / HT;
            e.hs = !(qx >= 1048 && qx <= 1183);
            e.vs = !(qy >= VA + VF && qy <= VA + VF + VS - 1);
            if (qx < HA && qy < VA) begin
                xb    = 8'(qx);
                e.rgb = xb ^ salt;
`ifdef VGA_TEST_PATTERN_EN
                if (pattern_sel) begin
                    idx   = (qx / 128) % 8;
                    e.rgb = ((idx / 4) % 2 == 1 ? 8'hE0 : 8'h00) |
                            ((idx / 2) % 2 == 1 ? 8'h1C : 8'h00) |
                            (idx % 2 == 1 ? 8'h03 : 8'h00);
                end
`endif
            end
        end
        return e;
    endfunction

    function automatic int pin_x(input int k);
        return (k > OUT_LAT) ? ((k - OUT_LAT - 1) % FRAME) % HT : -1;
    endfunction

    // Advance one clock; the pixel source answers each request LAT cycles later.
    task automatic tick();
        @(posedge clock);
        #1;
        if (reset) n++;
        bus.pixel_in = hist2;
        hist2 = hist1;
        hist1 = bus.req_active ? (bus.req_x[7:0] ^ salt) : 8'($urandom);
    endtask

    task automatic wait_pin_x(input int target, output bit found);
        found = 1'b0;
        for (int i = 0; i < 2 * HT && !found; i++) begin
            tick();
            found = (pin_x(n) == target);
        end
    endtask

    // Continuous scoreboard against the raster model, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            e = model_at(n);
            n_checks++;
            if (bus.req_x !== 11'(e.x)) begin
                n_fails++; $display("FAIL req_x n=%0d got=%0d exp=%0d", n, bus.req_x, e.x);
            end
            n_checks++;
            if (bus.req_y !== 10'(e.y)) begin
                n_fails++; $display("FAIL req_y n=%0d got=%0d exp=%0d", n, bus.req_y, e.y);
            end
            n_checks++;
            if (bus.req_active !== e.act) begin
                n_fails++; $display("FAIL req_active n=%0d got=%b exp=%b", n, bus.req_active, e.act);
            end
            n_checks++;
            if (bus.frame_start !== e.fs) begin
                n_fails++; $display("FAIL frame_start n=%0d got=%b exp=%b", n, bus.frame_start, e.fs);
            end
            n_checks++;
            if (Hsync !== e.hs) begin
                n_fails++; $display("FAIL Hsync n=%0d got=%b exp=%b", n, Hsync, e.hs);
            end
            n_checks++;
            if (Vsync !== e.vs) begin
                n_fails++; $display("FAIL Vsync n=%0d got=%b exp=%b", n, Vsync, e.vs);
            end
            n_checks++;
            if (rgb_pins !== e.rgb) begin
                n_fails++; $display("FAIL rgb n=%0d got=%02h exp=%02h", n, rgb_pins, e.rgb);
            end
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if ({Hsync, Vsync, rgb_pins} !== {1'b1, 1'b1, 8'h00}) begin
            n_fails++; $display("FAIL reset_pins got=%b%b/%02h exp=11/00", Hsync, Vsync, rgb_pins);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({bus.frame_start, bus.req_x, bus.req_y} !== {1'b1, 11'd0, 10'd0}) begin
            n_fails++; $display("FAIL first_edge fs=%b x=%0d y=%0d exp fs=1 x=0 y=0",
                                bus.frame_start, bus.req_x, bus.req_y);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_checks++;
            if (bus.req_x !== 11'(i)) begin
                n_fails++; $display("FAIL count_up got=%0d exp=%0d", bus.req_x, i);
            end
        end
    endtask

    task automatic test_hsync_line();
        int  fall1 = -1, fall2 = -1, len1 = -1;
        logic prev = Hsync;
        while (n < 2 * HT + OUT_LAT + 1200) begin
            tick();
            if (prev && !Hsync) begin
                if (fall1 < 0) fall1 = n; else if (fall2 < 0) fall2 = n;
            end
            if (!prev && Hsync && len1 < 0 && fall1 >= 0) len1 = n - fall1;
            prev = Hsync;
        end
        n_checks++;
        if (fall1 !== 1 + 1048 + OUT_LAT) begin
            n_fails++; $display("FAIL hsync_start got=%0d exp=%0d", fall1, 1 + 1048 + OUT_LAT);
        end
        n_checks++;
        if (len1 !== 136) begin
            n_fails++; $display("FAIL hsync_width got=%0d exp=136", len1);
        end
        n_checks++;
        if (fall2 - fall1 !== 1344) begin
            n_fails++; $display("FAIL line_period got=%0d exp=1344", fall2 - fall1);
        end
    endtask

    task automatic test_frame();
        int   vfall = -1, vlen = -1, fs2 = -1;
        logic prev = Vsync;
        while (n < FRAME + 20) begin
            tick();
            if (prev && !Vsync && vfall < 0) vfall = n;
            if (!prev && Vsync && vlen < 0 && vfall >= 0) vlen = n - vfall;
            if (bus.frame_start && n > 1 && fs2 < 0) fs2 = n;
            prev = Vsync;
        end
        n_checks++;
        if (vfall !== 1 + (VA + VF) * HT + OUT_LAT) begin
            n_fails++; $display("FAIL vsync_start got=%0d exp=%0d", vfall, 1 + (VA + VF) * HT + OUT_LAT);
        end
        n_checks++;
        if (vlen !== VS * HT) begin
            n_fails++; $display("FAIL vsync_width got=%0d exp=%0d", vlen, VS * HT);
        end
        n_checks++;
        if (fs2 !== FRAME + 1) begin
            n_fails++; $display("FAIL frame_period got=%0d exp=%0d", fs2, FRAME + 1);
        end
    endtask

    task automatic test_reset_mid();
        int   target = $urandom_range(2, 6) * HT + 1100;
        int   hold   = $urandom_range(3, 12);
        int   fall   = -1;
        logic prev;
        for (int i = 0; i < FRAME && ((n - 1) % FRAME) != target; i++) tick();
        n_checks++;
        if (Hsync !== 1'b0) begin
            n_fails++; $display("FAIL pre_reset_hsync got=%b exp=0", Hsync);
        end
        #2;
        reset = 1'b0;
        n = 0;
        #1;
        n_checks++;
        if ({Hsync, Vsync, rgb_pins, bus.req_x} !== {1'b1, 1'b1, 8'h00, 11'd0}) begin
            n_fails++; $display("FAIL async_reset got hs=%b vs=%b rgb=%02h x=%0d exp 1 1 00 0",
                                Hsync, Vsync, rgb_pins, bus.req_x);
        end
        for (int i = 0; i < hold; i++) tick();
        salt  = 8'($urandom);
        reset = 1'b1;
        prev  = Hsync;
        for (int i = 0; i < HT + OUT_LAT + 100; i++) begin
            tick();
            if (prev && !Hsync && fall < 0) fall = n;
            prev = Hsync;
        end
        n_checks++;
        if (fall !== 1 + 1048 + OUT_LAT) begin
            n_fails++; $display("FAIL post_reset_hsync got=%0d exp=%0d", fall, 1 + 1048 + OUT_LAT);
        end
    endtask

    task automatic test_pattern();
        bit         found;
        int         xr = $urandom_range(0, 1023);
        logic [7:0] exp_bar;
        wait_pin_x(1200, found);
        pattern_sel = 1'b1;
        wait_pin_x(300, found);
        n_checks++;
`ifdef VGA_TEST_PATTERN_EN
        if (!found || rgb_pins !== 8'b0001_1100) begin
            n_fails++; $display("FAIL pattern_x300 got=%02h exp=1c", rgb_pins);
        end
`else
        if (!found || rgb_pins !== (8'h2C ^ salt)) begin
            n_fails++; $display("FAIL pattern_ignored got=%02h exp=%02h", rgb_pins, 8'h2C ^ salt);
        end
`endif
        wait_pin_x(xr, found);
        exp_bar = model_at(n).rgb;
        n_checks++;
        if (!found || rgb_pins !== exp_bar) begin
            n_fails++; $display("FAIL pattern_rand x=%0d got=%02h exp=%02h", xr, rgb_pins, exp_bar);
        end
        wait_pin_x(1200, found);
        pattern_sel = 1'b0;
        wait_pin_x(300, found);
        n_checks++;
        if (!found || rgb_pins !== (8'h2C ^ salt)) begin
            n_fails++; $display("FAIL pattern_off got=%02h exp=%02h", rgb_pins, 8'h2C ^ salt);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog n=%0d", n);
        $fatal(1, "bench timed out");
    end

    initial begin
        n = 0;
        n_checks = 0;
        n_fails = 0;
        salt = 8'($urandom);
        hist1 = 8'h00;
        hist2 = 8'h00;
        bus.pixel_in = 8'h00;
        test_reset();
        test_hsync_line();
        test_frame();
        test_reset_mid();
        test_pattern();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
